mcdf_fmt_rx: RTL

//  Downstream responder for the MCDF formatter request/grant/data interface.

---
 rtl/mcdf_fmt_rx_if.sv | 37 +++
 rtl/mcdf_fmt_rx.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mcdf_fmt_rx_if.sv
// Formatter-side request/grant/data bundle plus forwarded beat stream and status.
// The slave modport is the receiver's view; master is the formatter/sink side.
interface mcdf_fmt_rx_if #(
  parameter int CNT_W = 16
);
  logic               fmt_req_i;
  logic [1:0]         fmt_chid_i;
  logic [5:0]         fmt_length_i;
  logic [31:0]        fmt_data_i;
  logic               fmt_start_i;
  logic               fmt_end_i;
  logic               rx_stall_i;
  logic               err_clr_i;
  logic               fmt_grant_o;
  logic               pkt_vld_o;
  logic [31:0]        pkt_data_o;
  logic               pkt_sop_o;
  logic               pkt_eop_o;
  logic [1:0]         pkt_chid_o;
  logic [3*CNT_W-1:0] pkt_cnt_o;
  logic [4:0]         err_o;
  logic               busy_o;

  modport slave (
    input  fmt_req_i, fmt_chid_i, fmt_length_i, fmt_data_i, fmt_start_i, fmt_end_i,
           rx_stall_i, err_clr_i,
    output fmt_grant_o, pkt_vld_o, pkt_data_o, pkt_sop_o, pkt_eop_o, pkt_chid_o,
           pkt_cnt_o, err_o, busy_o
  );

  modport master (
    output fmt_req_i, fmt_chid_i, fmt_length_i, fmt_data_i, fmt_start_i, fmt_end_i,
           rx_stall_i, err_clr_i,
    input  fmt_grant_o, pkt_vld_o, pkt_data_o, pkt_sop_o, pkt_eop_o, pkt_chid_o,
           pkt_cnt_o, err_o, busy_o
  );
endinterface

// File: rtl/mcdf_fmt_rx.sv
// Grants formatter requests after GRANT_DLY wait cycles, forwards each beat one cycle late.
// Stall only blocks new grants; an accepted packet cannot be backpressured.
module mcdf_fmt_rx #(
  parameter int GRANT_DLY = 2,
  parameter int START_TMO = 4,
  parameter int CNT_W     = 16
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  mcdf_fmt_rx_if.slave       bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GRANT, S_RECV} state_t;

  state_t                  r_state;
  logic [7:0]              r_dly;
  logic [7:0]              r_tmo;
  logic [1:0]              r_chid;
  logic [5:0]              r_len;
  logic [5:0]              r_beat;
  logic                    r_inpkt;
  logic                    r_first;
  logic                    r_grant;
  logic                    r_vld;
  logic                    r_sop;
  logic                    r_eop;
  logic [31:0]             r_data;
  logic [4:0]              r_err;
  logic [2:0][CNT_W-1:0]   r_cnt;

  logic [5:0]              w_beat_n;
  logic                    w_last;

  assign w_beat_n = r_inpkt ? (r_beat + 6'd1) : 6'd1;
  assign w_last   = (w_beat_n == r_len);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= S_IDLE;
      r_dly   <= '0;
      r_tmo   <= '0;
      r_chid  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_inpkt <= 1'b0;
      r_first <= 1'b0;
      r_grant <= 1'b0;
      r_vld   <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_data  <= '0;
      r_err   <= '0;
      r_cnt   <= '0;
    end else begin
      r_grant <= 1'b0;
      r_vld   <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      // Clear first so any error bit set later in this cycle takes priority.
      if (bus.err_clr_i) r_err <= '0;
      case (r_state)
        S_IDLE: begin
          if (bus.fmt_req_i && !bus.rx_stall_i) begin
            if (bus.fmt_length_i == 6'd0) begin
              r_err[4] <= 1'b1;
            end else if (GRANT_DLY == 0) begin
              r_state <= S_GRANT;
              r_grant <= 1'b1;
            end else begin
              r_state <= S_WAIT;
              r_dly   <= 8'(GRANT_DLY);
            end
          end
        end
        S_WAIT: begin
          if (!bus.fmt_req_i) begin
            r_state <= S_IDLE;
          end else if (r_dly <= 8'd1) begin
            r_state <= S_GRANT;
            r_grant <= 1'b1;
          end else begin
            r_dly <= r_dly - 8'd1;
          end
        end
        S_GRANT: begin
          r_chid  <= bus.fmt_chid_i;
          r_len   <= bus.fmt_length_i;
          r_tmo   <= '0;
          r_first <= 1'b1;
          r_inpkt <= 1'b0;
          r_state <= S_RECV;
        end
        S_RECV: begin
          r_first <= 1'b0;
          if (r_first && bus.fmt_req_i) r_err[0] <= 1'b1;
          if (r_inpkt || bus.fmt_start_i) begin
            r_vld   <= 1'b1;
            r_sop   <= !r_inpkt;
            r_data  <= bus.fmt_data_i;
            r_beat  <= w_beat_n;
            r_inpkt <= 1'b1;
            if (r_inpkt && bus.fmt_start_i) r_err[2] <= 1'b1;
            // Packet closes on end marker or on the last expected beat, whichever first.
            if (bus.fmt_end_i || w_last) begin
              r_eop   <= 1'b1;
              r_inpkt <= 1'b0;
              r_state <= S_IDLE;
              if (bus.fmt_end_i && w_last) begin
                if (r_chid != 2'd3) r_cnt[r_chid] <= r_cnt[r_chid] + CNT_W'(1);
              end else begin
                r_err[1] <= 1'b1;
              end
            end
          end else if (r_tmo == 8'(START_TMO - 1)) begin
            r_err[3] <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.fmt_grant_o = r_grant;
  assign bus.pkt_vld_o   = r_vld;
  assign bus.pkt_data_o  = r_data;
  assign bus.pkt_sop_o   = r_sop;
  assign bus.pkt_eop_o   = r_eop;
  assign bus.pkt_chid_o  = r_chid;
  assign bus.pkt_cnt_o   = r_cnt;
  assign bus.err_o       = r_err;
  assign bus.busy_o      = (r_state != S_IDLE);

endmodule
